// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and default widths for the data-memory responder
package dmem_pkg;

   localparam int DMEM_ADDR_WIDTH = 16;
   localparam int DMEM_DATA_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_ACK  = 3'd3,
      RELEASE = 3'd4
   } dmem_state_t;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port synchronous RAM with registered output
module dmem_ram #(
   parameter int AW    = 12,
   parameter int DW    = 16,
   parameter int DEPTH = 4096
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_dout
);

   logic [DW-1:0] r_mem [DEPTH];

   // No reset on the array or output so the block maps onto a block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_din;
      end
      o_dout <= r_mem[i_addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - four-phase read/write responder over an internal RAM
// Optional feature: define DMEM_RANGE_CHECK_EN to reject addresses >= DEPTH with err.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int DEPTH      = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  done,
   output logic                  busy,
   output logic                  err
);

   localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif

   dmem_state_t     r_state;
   logic [RAW-1:0]  r_addr;
   logic            r_oor;

   logic            w_oor;
   logic            w_ram_we;
   logic [RAW-1:0]  w_ram_addr;
   logic [DATA_WIDTH-1:0] w_ram_dout;

   assign w_oor      = RANGE_CHECK && (64'(addr) >= 64'(DEPTH));
   // The write commits on the acceptance edge, so the RAM sees the live bus in IDLE.
   assign w_ram_we   = (r_state == IDLE) && write && !read && !w_oor;
   assign w_ram_addr = (r_state == IDLE) ? addr[RAW-1:0] : r_addr;

   dmem_ram #(
      .AW    (RAW),
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk    (clk),
      .i_we   (w_ram_we),
      .i_addr (w_ram_addr),
      .i_din  (wdata),
      .o_dout (w_ram_dout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_oor   <= 1'b0;
         rdata   <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (read && write) begin
                  busy    <= 1'b1;
                  err     <= 1'b1;
                  r_state <= RELEASE;
               end else if (read) begin
                  busy    <= 1'b1;
                  r_addr  <= addr[RAW-1:0];
                  r_oor   <= w_oor;
                  r_state <= RD_ADDR;
               end else if (write) begin
                  busy    <= 1'b1;
                  r_oor   <= w_oor;
                  r_state <= WR_ACK;
               end
            end
            RD_ADDR: r_state <= RD_DATA;
            RD_DATA: begin
               done <= 1'b1;
               err  <= r_oor;
               if (!r_oor) begin
                  rdata <= w_ram_dout;
               end
               r_state <= RELEASE;
            end
            WR_ACK: begin
               done    <= 1'b1;
               err     <= r_oor;
               r_state <= RELEASE;
            end
            RELEASE: begin
               if (!read && !write) begin
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder handshake, latency and data
module tb_dmem_responder;

`ifdef DMEM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        read;
   logic        write;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        done;
   logic        busy;
   logic        err;

   typedef struct {
      int          cyc;
      bit          done;
      bit          err;
      logic [15:0] rdata;
   } exp_t;

   exp_t        q[$];
   logic [15:0] model [4096];
   logic [15:0] exp_rdata;
   int          cyc;
   int          n_checks;
   int          n_errors;

   dmem_responder #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (16),
      .DEPTH      (4096)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .read  (read),
      .write (write),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .done  (done),
      .busy  (busy),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit is_oor(input logic [15:0] a);
      return RC && (a >= 16'd4096);
   endfunction

   // Every done or err pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (rst_n && (done || err)) begin
         if (q.size() == 0) begin
            chk("unexpected_event", {30'd0, done, err}, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("done", done, e.done);
            chk("err", err, e.err);
            chk("rdata", rdata, e.rdata);
         end
      end
   end

   task automatic wait_done();
      int n = 0;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_seen", done, 1);
   endtask

   task automatic release_req(input string tag);
      chk({tag, "_busy_held"}, busy, 1);
      read  = 1'b0;
      write = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_busy_fall"}, busy, 0);
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int hold);
      exp_t e;
      @(posedge clk); #1;
      write = 1'b1; addr = a; wdata = d;
      e.cyc = cyc + 2; e.done = 1'b1; e.err = is_oor(a); e.rdata = exp_rdata;
      q.push_back(e);
      if (!is_oor(a)) model[a[11:0]] = d;
      @(posedge clk); #1;
      addr = ~a; wdata = ~d;
      wait_done();
      repeat (hold) begin @(posedge clk); #1; end
      release_req("wr");
   endtask

   task automatic do_read(input logic [15:0] a, input int hold);
      exp_t e;
      @(posedge clk); #1;
      read = 1'b1; addr = a;
      if (!is_oor(a)) exp_rdata = model[a[11:0]];
      e.cyc = cyc + 3; e.done = 1'b1; e.err = is_oor(a); e.rdata = exp_rdata;
      q.push_back(e);
      @(posedge clk); #1;
      addr = ~a;
      wait_done();
      repeat (hold) begin @(posedge clk); #1; end
      release_req("rd");
   endtask

   task automatic do_conflict(input logic [15:0] a, input logic [15:0] d);
      exp_t e;
      @(posedge clk); #1;
      read = 1'b1; write = 1'b1; addr = a; wdata = d;
      e.cyc = cyc + 1; e.done = 1'b0; e.err = 1'b1; e.rdata = exp_rdata;
      q.push_back(e);
      @(posedge clk); #1;
      repeat (3) begin @(posedge clk); #1; end
      release_req("conf");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      exp_rdata = 16'h0000;
      rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", rdata, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;

      do_write(16'h0005, 16'h00A7, 0);
      do_read(16'h0005, 0);
      do_write(16'h0006, 16'h1234, 2);
      chk("rdata_hold_after_wr", rdata, 16'h00A7);

      do_conflict(16'h0005, 16'hFFFF);
      do_read(16'h0005, 0);

      do_read(16'h0006, 10);

      // Reset while the read sits in RD_ADDR.
      @(posedge clk); #1;
      read = 1'b1; addr = 16'h0006;
      @(posedge clk); #1;
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_done", done, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_err", err, 0);
      chk("midrst_rdata", rdata, 0);
      exp_rdata = 16'h0000;
      read = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      do_read(16'h0005, 0);

      // Out-of-range address: truncated by default, rejected with range checking.
      do_write(16'h0000, 16'h5A5A, 0);
      do_write(16'h1000, 16'hC3C3, 0);
      do_read(16'h0000, 0);
      do_read(16'h1000, 0);

      for (int i = 0; i < 6; i++) begin
         logic [15:0] ra;
         logic [15:0] rd;
         ra = 16'h0100 + 16'($urandom_range(0, 15));
         rd = 16'($urandom);
         do_write(ra, rd, $urandom_range(0, 2));
         do_read(ra, $urandom_range(0, 2));
      end

      repeat (4) @(posedge clk);
      #1;
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
